// File: rtl/mask_pkg.sv
// Shared types and constants for the masked-gadget drivers: share vectors, FSM states, LFSR taps.
package mask_pkg;

    localparam int unsigned NSHARES = 6;
    localparam int unsigned NRAND   = 5;

    // Galois form of x^32 + x^22 + x^2 + x + 1 for a right-shifting register
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    typedef logic [NSHARES-1:0] share_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_RESULT = 2'd2
    } drv_state_e;

    function automatic logic xor_reduce_shares(input share_t s);
        return ^s;
    endfunction

endpackage

// File: rtl/mask_lfsr.sv
// Free-running Galois LFSR used as the mask source; steps every clock once out of reset.
module mask_lfsr
    import mask_pkg::*;
#(
    parameter int unsigned      WIDTH = 32,
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [WIDTH-1:0] state_o
);

    // An all-zero state would lock the register, so a zero seed is forced to 1
    localparam logic [WIDTH-1:0] SEED_NZ = (SEED == '0) ? WIDTH'(1) : SEED;
    localparam logic [WIDTH-1:0] TAPS    = WIDTH'(LFSR_TAPS);

    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] state_d;

    always_comb begin
        state_d = {1'b0, state_q[WIDTH-1:1]};
        if (state_q[0]) begin
            state_d = state_d ^ TAPS;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SEED_NZ;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/mul5_share_driver.sv
// Masks an (a,b) bit pair into 6 shares each for the Mul5 gadget, waits its latency,
// then captures the z shares and presents their XOR as the unmasked result.
module mul5_share_driver
    import mask_pkg::*;
#(
    parameter int unsigned GADGET_LAT = 1,
    parameter logic [31:0] SEED       = 32'hACE1_2468
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               a_i,
    input  logic               b_i,
    output logic [NSHARES-1:0] x_o,
    output logic [NSHARES-1:0] y_o,
    output logic [NRAND-1:0]   r_o,
    input  logic [NSHARES-1:0] z_i,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_bit,
    output logic [NSHARES-1:0] out_shares
);

    localparam int unsigned LFSR_W = 32;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned MSK_W  = NSHARES - 1;

    drv_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    share_t             x_q, x_d;
    share_t             y_q, y_d;
    logic [NRAND-1:0]   r_q, r_d;
    share_t             z_q, z_d;
    logic               out_valid_q, out_valid_d;
    logic               out_bit_q, out_bit_d;
    logic               in_ready_q, in_ready_d;

    logic [LFSR_W-1:0]  lfsr_state;
    logic [MSK_W-1:0]   mx, my;
    logic [NRAND-1:0]   mr;
    logic               unused_lfsr_bits;

    mask_lfsr #(
        .WIDTH (LFSR_W),
        .SEED  (SEED)
    ) u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .state_o (lfsr_state)
    );

    // Masks are taken from the low 15 bits of the current LFSR state
    assign mx = lfsr_state[4:0];
    assign my = lfsr_state[9:5];
    assign mr = lfsr_state[14:10];
    assign unused_lfsr_bits = ^lfsr_state[LFSR_W-1:15];

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        x_d         = x_q;
        y_d         = y_q;
        r_d         = r_q;
        z_d         = z_q;
        out_valid_d = out_valid_q;
        out_bit_d   = out_bit_q;
        in_ready_d  = in_ready_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    x_d        = {a_i ^ (^mx), mx};
                    y_d        = {b_i ^ (^my), my};
                    r_d        = mr;
                    cnt_d      = CNT_W'(GADGET_LAT);
                    in_ready_d = 1'b0;
                    state_d    = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    z_d         = z_i;
                    out_bit_d   = xor_reduce_shares(z_i);
                    out_valid_d = 1'b1;
                    // Return the gadget inputs to zero between operations
                    x_d         = '0;
                    y_d         = '0;
                    r_d         = '0;
                    state_d     = ST_RESULT;
                end
            end
            ST_RESULT: begin
                if (out_ready) begin
                    z_d         = '0;
                    out_bit_d   = 1'b0;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                cnt_d       = '0;
                x_d         = '0;
                y_d         = '0;
                r_d         = '0;
                z_d         = '0;
                out_bit_d   = 1'b0;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            x_q         <= '0;
            y_q         <= '0;
            r_q         <= '0;
            z_q         <= '0;
            out_valid_q <= 1'b0;
            out_bit_q   <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            x_q         <= x_d;
            y_q         <= y_d;
            r_q         <= r_d;
            z_q         <= z_d;
            out_valid_q <= out_valid_d;
            out_bit_q   <= out_bit_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign x_o        = x_q;
    assign y_o        = y_q;
    assign r_o        = r_q;
    assign out_valid  = out_valid_q;
    assign out_bit    = out_bit_q;
    assign out_shares = z_q;

endmodule

// File: tb/tb_mul5_share_driver.sv
// Directed bench: two drivers (gadget latency 1 and 3) each in front of a behavioural Mul5 model.
module tb_mul5_share_driver;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Latency-1 instance
    logic       in_valid, in_ready, a, b, out_valid, out_ready, out_bit;
    logic [5:0] x, y, z, out_shares;
    logic [4:0] r;

    // Latency-3 instance
    logic       in_valid3, in_ready3, a3, b3, out_valid3, out_ready3, out_bit3;
    logic [5:0] x3, y3, z3, out_shares3;
    logic [4:0] r3;
    logic [5:0] g3_s1, g3_s2;

    int errors = 0;
    int checks = 0;

    // Behavioural Mul5: five output shares are r, the sixth completes the XOR to a&b
    function automatic logic [5:0] gadget(input logic [5:0] xs, input logic [5:0] ys,
                                          input logic [4:0] rs);
        gadget = {((^xs) & (^ys)) ^ (^rs), rs};
    endfunction

    assign z = gadget(x, y, r);

    always @(posedge clk) begin
        g3_s1 <= gadget(x3, y3, r3);
        g3_s2 <= g3_s1;
    end
    assign z3 = g3_s2;

    mul5_share_driver #(.GADGET_LAT(1), .SEED(32'hACE1_2468)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .a_i(a), .b_i(b),
        .x_o(x), .y_o(y), .r_o(r), .z_i(z),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_bit(out_bit), .out_shares(out_shares)
    );

    mul5_share_driver #(.GADGET_LAT(3), .SEED(32'hACE1_2468)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid3), .in_ready(in_ready3), .a_i(a3), .b_i(b3),
        .x_o(x3), .y_o(y3), .r_o(r3), .z_i(z3),
        .out_valid(out_valid3), .out_ready(out_ready3),
        .out_bit(out_bit3), .out_shares(out_shares3)
    );

    // SEED[14:0]=0x2468 -> mx=01000, my=00011, mr=01001; with a=b=1:
    // x=6'h08, y=6'h23, r=5'h09, z={1,01001}=6'h29
    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; a = 1'b0; b = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if ({x, y, r} !== 17'h0) begin errors++; $display("FAIL reset_shares: got %h want 0", {x, y, r}); end
        checks++; if ({out_bit, out_shares} !== 7'h0) begin errors++; $display("FAIL reset_result: got %h want 0", {out_bit, out_shares}); end
        rst_n = 1'b1; in_valid = 1'b1; a = 1'b1; b = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL seed_in_ready: got %b want 0", in_ready); end
        checks++; if (x !== 6'h08) begin errors++; $display("FAIL seed_x: got %h want 08", x); end
        checks++; if (y !== 6'h23) begin errors++; $display("FAIL seed_y: got %h want 23", y); end
        checks++; if (r !== 5'h09) begin errors++; $display("FAIL seed_r: got %h want 09", r); end
        @(negedge clk);
        checks++; if ({out_valid, out_bit} !== 2'b11) begin errors++; $display("FAIL seed_result: got %b want 11", {out_valid, out_bit}); end
        checks++; if (out_shares !== 6'h29) begin errors++; $display("FAIL seed_out_shares: got %h want 29", out_shares); end
        checks++; if (x !== 6'h00) begin errors++; $display("FAIL seed_precharge: got %h want 00", x); end
        @(negedge clk);
        checks++; if ({out_valid, in_ready, out_shares} !== 8'b01_000000) begin errors++; $display("FAIL seed_release: got %b want 01000000", {out_valid, in_ready, out_shares}); end
    endtask

    task automatic test_truth_table();
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a = i[1]; b = i[0];
            @(negedge clk);
            checks++; if ({in_ready, ^x, ^y} !== {1'b0, a, b}) begin errors++; $display("FAIL tt_drive%0d: got %b want %b", i, {in_ready, ^x, ^y}, {1'b0, a, b}); end
            @(negedge clk);
            checks++; if ({out_valid, out_bit} !== {1'b1, a & b}) begin errors++; $display("FAIL tt_result%0d: got %b want %b", i, {out_valid, out_bit}, {1'b1, a & b}); end
            checks++; if (x !== 6'h00) begin errors++; $display("FAIL tt_precharge%0d: got %h want 00", i, x); end
            @(negedge clk);
            checks++; if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL tt_idle%0d: got %b want 01", i, {out_valid, in_ready}); end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_share_masks();
        logic [4:0] first_mx;
        logic       varied;
        first_mx = 5'h0; varied = 1'b0;
        out_ready = 1'b1; in_valid = 1'b1; a = 1'b1; b = 1'b1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            checks++; if ({^x, ^y} !== 2'b11) begin errors++; $display("FAIL mask_parity%0d: got %b want 11", n, {^x, ^y}); end
            if (n == 0) first_mx = x[4:0];
            else if (x[4:0] != first_mx) varied = 1'b1;
            @(negedge clk);
            checks++; if ({x, y, r, out_bit} !== 18'h1) begin errors++; $display("FAIL mask_result%0d: got %h want 1", n, {x, y, r, out_bit}); end
            @(negedge clk);
            checks++; if ({x, y, r, out_valid} !== 18'h0) begin errors++; $display("FAIL mask_idle%0d: got %h want 0", n, {x, y, r, out_valid}); end
        end
        in_valid = 1'b0;
        checks++; if (varied !== 1'b1) begin errors++; $display("FAIL mask_varies: got %b want 1", varied); end
    endtask

    task automatic test_backpressure();
        logic [5:0] exp_shares;
        out_ready = 1'b0; in_valid = 1'b1; a = 1'b1; b = 1'b0;
        @(negedge clk);
        exp_shares = gadget(x, y, r);
        a = 1'b1; b = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++; if ({out_valid, out_bit, in_ready} !== 3'b100) begin errors++; $display("FAIL bp_hold%0d: got %b want 100", k, {out_valid, out_bit, in_ready}); end
            checks++; if (out_shares !== exp_shares) begin errors++; $display("FAIL bp_shares%0d: got %h want %h", k, out_shares, exp_shares); end
            checks++; if (x !== 6'h00) begin errors++; $display("FAIL bp_no_accept%0d: got %h want 00", k, x); end
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if ({out_valid, in_ready, out_shares} !== 8'b01_000000) begin errors++; $display("FAIL bp_release: got %b want 01000000", {out_valid, in_ready, out_shares}); end
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if ({in_ready, ^x, ^y} !== 3'b011) begin errors++; $display("FAIL bp_pending: got %b want 011", {in_ready, ^x, ^y}); end
        @(negedge clk);
        checks++; if ({out_valid, out_bit} !== 2'b11) begin errors++; $display("FAIL bp_pending_result: got %b want 11", {out_valid, out_bit}); end
        @(negedge clk);
    endtask

    task automatic test_abort();
        out_ready = 1'b1; in_valid = 1'b1; a = 1'b1; b = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++; if ({in_ready, out_valid, x, y, r} !== 19'h40000) begin errors++; $display("FAIL abort_clear: got %h want 40000", {in_ready, out_valid, x, y, r}); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_no_out: got %b want 0", out_valid); end
        rst_n = 1'b1; in_valid = 1'b1; a = 1'b1; b = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if ({x, y} !== 12'h223) begin errors++; $display("FAIL abort_seed_restart: got %h want 223", {x, y}); end
        @(negedge clk);
        checks++; if ({out_valid, out_bit} !== 2'b11) begin errors++; $display("FAIL abort_next_op: got %b want 11", {out_valid, out_bit}); end
        @(negedge clk);
    endtask

    task automatic test_lat3();
        out_ready3 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a3 = i[1]; b3 = i[0]; in_valid3 = 1'b1;
            @(negedge clk);
            in_valid3 = 1'b0;
            for (int c = 0; c < 3; c++) begin
                checks++; if ({in_ready3, out_valid3, ^x3, ^y3} !== {2'b00, a3, b3}) begin errors++; $display("FAIL lat3_drive%0d_%0d: got %b want %b", i, c, {in_ready3, out_valid3, ^x3, ^y3}, {2'b00, a3, b3}); end
                @(negedge clk);
            end
            checks++; if ({out_valid3, out_bit3} !== {1'b1, a3 & b3}) begin errors++; $display("FAIL lat3_result%0d: got %b want %b", i, {out_valid3, out_bit3}, {1'b1, a3 & b3}); end
            checks++; if ({x3, y3, r3} !== 17'h0) begin errors++; $display("FAIL lat3_precharge%0d: got %h want 0", i, {x3, y3, r3}); end
            @(negedge clk);
            checks++; if ({out_valid3, in_ready3} !== 2'b01) begin errors++; $display("FAIL lat3_idle%0d: got %b want 01", i, {out_valid3, in_ready3}); end
        end
    endtask

    initial begin
        in_valid3 = 1'b0; a3 = 1'b0; b3 = 1'b0; out_ready3 = 1'b1;
        test_reset();
        test_truth_table();
        test_share_masks();
        test_backpressure();
        test_abort();
        test_lat3();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
